// File: rtl/morse_pkg.sv
// morse_pkg: shared types and A-Z Morse tables for the character encoder.
// Holds the FSM state enum, character-code width, maximum symbols per letter,
// and per-letter length/pattern tables (pattern LSB = first symbol, 1 = dash).
package morse_pkg;
    localparam int CHAR_W    = 5;
    localparam int MAX_SYM   = 4;
    localparam int NUM_CHARS = 26;
    typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;
    localparam logic [2:0] MORSE_LEN [NUM_CHARS] = '{
        3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4, 3'd2, 3'd4, 3'd3, 3'd4, 3'd2,
        3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd1, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4, 3'd4
    };
    localparam logic [MAX_SYM-1:0] MORSE_PAT [NUM_CHARS] = '{
        4'b0010, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0100, 4'b0011, 4'b0000, 4'b0000,
        4'b1110, 4'b0101, 4'b0010, 4'b0011, 4'b0001, 4'b0111, 4'b0110, 4'b1011, 4'b0010,
        4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b0110, 4'b1001, 4'b1101, 4'b0011
    };
endpackage

// File: rtl/morse_char_rom.sv
// morse_char_rom: combinational A-Z lookup.
// Ports: char_i  - character code (0=A .. 25=Z)
//        entry_o - {valid, length[2:0], pattern[3:0]}; valid=0 for codes 26..31
module morse_char_rom
    import morse_pkg::*;
(
    input  logic [CHAR_W-1:0] char_i,
    output logic [7:0]        entry_o
);
    logic              valid;
    logic [CHAR_W-1:0] idx;
    // Invalid codes are steered to entry 0 so the table is never indexed out of range.
    assign valid   = char_i < CHAR_W'(NUM_CHARS);
    assign idx     = valid ? char_i : '0;
    assign entry_o = {valid, MORSE_LEN[idx], MORSE_PAT[idx]};
endmodule

// File: rtl/morse_char_encoder.sv
// morse_char_encoder: keys one A-Z character at a time as Morse on z.
// Ports: clk, rst (async, active-high)
//        in_valid/in_char/in_ready - character handshake (accepted only in IDLE)
//        z    - registered key output, 1 = mark
//        busy - character in progress; done - end-of-letter pulse
//        err  - pulse after an invalid code (26..31) was accepted and dropped
module morse_char_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES      = 4,
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    output logic              in_ready,
    output logic              z,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int DASH_LEN = DASH_UNITS * UNIT_CYCLES;
    localparam int GAP_LEN  = LETTER_GAP_UNITS * UNIT_CYCLES;
    localparam int MAX_LEN  = DASH_LEN > GAP_LEN ? DASH_LEN : GAP_LEN;
    localparam int CW       = $clog2(MAX_LEN) + 1;
    // Counters load duration-1 so a state lasts exactly its duration.
    localparam logic [CW-1:0] DOT_C  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_C = CW'(DASH_LEN - 1);
    localparam logic [CW-1:0] GAP_C  = CW'(GAP_LEN - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [2:0]           len_q, len_d;
    logic [MAX_SYM-1:0]   pat_q, pat_d;
    logic                 z_q, err_q, err_d;
    logic [7:0]           rom_entry;

    morse_char_rom u_rom (
        .char_i  (in_char),
        .entry_o (rom_entry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pat_d   = pat_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: if (in_valid) begin
                if (rom_entry[7]) begin
                    len_d   = rom_entry[6:4];
                    pat_d   = rom_entry[3:0];
                    idx_d   = 2'd0;
                    cnt_d   = rom_entry[0] ? DASH_C : DOT_C;
                    state_d = MARK;
                end else begin
                    err_d = 1'b1;
                end
            end
            MARK: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if ({1'b0, idx_q} + 3'd1 < len_q) begin
                cnt_d   = DOT_C;
                state_d = SPACE;
            end else begin
                cnt_d   = GAP_C;
                state_d = LGAP;
            end
            SPACE: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                idx_d   = idx_q + 2'd1;
                cnt_d   = pat_q[idx_q + 2'd1] ? DASH_C : DOT_C;
                state_d = MARK;
            end
            LGAP: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            z_q     <= state_d == MARK;
            err_q   <= err_d;
        end
    end

    assign z        = z_q;
    assign err      = err_q;
    assign in_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign done     = state_q == LGAP && cnt_q == '0;
endmodule

// File: tb/tb_morse_char_encoder.sv
// tb_morse_char_encoder: directed checks of the Morse character encoder.
module tb_morse_char_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_valid2 = 1'b0;
    logic [4:0] in_char = 5'd0, in_char2 = 5'd0;
    logic       in_ready, z, busy, done, err;
    logic       in_ready2, z2, busy2, done2, err2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    morse_char_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .z(z), .busy(busy), .done(done), .err(err)
    );

    morse_char_encoder #(.UNIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_char(in_char2),
        .in_ready(in_ready2), .z(z2), .busy(busy2), .done(done2), .err(err2)
    );

    // Expected z waveform from run lengths, alternating high/low starting high.
    function automatic logic [127:0] runs(input int r[12]);
        logic [127:0] v = '0;
        int p = 0;
        for (int k = 0; k < 12; k++)
            for (int j = 0; j < r[k]; j++) begin
                if (p < 128) v[p] = (k % 2 == 0);
                p++;
            end
        return v;
    endfunction

    // Records outputs for n cycles; bit i holds cycle i+1 after the transfer edge.
    // mode 0: drop in_valid after the first edge; 1: hold in_valid (char -> T) until
    // the next acceptance; 2: toggle in_valid/in_char while the character is sent.
    task automatic capture(input bit sel, input int n, input int mode,
                           output logic [127:0] zv, output logic [127:0] dv,
                           output logic [127:0] rv, output logic [127:0] ev);
        bit seen = 1'b0;
        logic v;
        logic [4:0] c;
        zv = '0; dv = '0; rv = '0; ev = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            zv[i] = sel ? z2 : z;
            dv[i] = sel ? done2 : done;
            rv[i] = sel ? in_ready2 : in_ready;
            ev[i] = sel ? err2 : err;
            v = 1'b0;
            c = sel ? in_char2 : in_char;
            if (mode == 1) begin
                v = !seen;
                if (i == 0) c = 5'd19;
                if (rv[i]) seen = 1'b1;
            end else if (mode == 2 && i < 48) begin
                v = i[0];
                c = 5'((i * 7) % 32);
            end
            if (sel) begin in_valid2 = v; in_char2 = c; end
            else begin in_valid = v; in_char = c; end
        end
    endtask

    task automatic test_reset;
        #1;
        checks += 5;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        if (z !== 1'b0) begin errors++; $display("FAIL reset_z got %b want 0", z); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_letter_a;
        logic [127:0] zv, dv, rv, ev, ez;
        ez = runs('{4, 4, 12, 12, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        in_valid = 1'b1; in_char = 5'd0;
        capture(1'b0, 33, 0, zv, dv, rv, ev);
        checks += 4;
        if (zv !== ez) begin errors++; $display("FAIL a_z got %h want %h", zv, ez); end
        if (dv !== 128'd1 << 31) begin errors++; $display("FAIL a_done got %h want %h", dv, 128'd1 << 31); end
        if (rv !== 128'd1 << 32) begin errors++; $display("FAIL a_ready got %h want %h", rv, 128'd1 << 32); end
        if (ev !== '0) begin errors++; $display("FAIL a_err got %h want 0", ev); end
    endtask

    task automatic test_unit1_e;
        logic [127:0] zv, dv, rv, ev;
        @(negedge clk);
        in_valid2 = 1'b1; in_char2 = 5'd4;
        capture(1'b1, 5, 0, zv, dv, rv, ev);
        checks += 4;
        if (zv !== 128'b00001) begin errors++; $display("FAIL e_z got %h want 1", zv); end
        if (dv !== 128'b01000) begin errors++; $display("FAIL e_done got %h want 8", dv); end
        if (rv !== 128'b10000) begin errors++; $display("FAIL e_ready got %h want 10", rv); end
        if (busy2 !== 1'b0) begin errors++; $display("FAIL e_busy got %b want 0", busy2); end
    endtask

    task automatic test_invalid;
        logic [127:0] zv, dv, rv, ev;
        @(negedge clk);
        in_valid = 1'b1; in_char = 5'd27;
        capture(1'b0, 4, 0, zv, dv, rv, ev);
        checks += 4;
        if (ev !== 128'b0001) begin errors++; $display("FAIL inv_err got %h want 1", ev); end
        if (zv !== '0) begin errors++; $display("FAIL inv_z got %h want 0", zv); end
        if (rv !== 128'b1111) begin errors++; $display("FAIL inv_ready got %h want f", rv); end
        if (dv !== '0) begin errors++; $display("FAIL inv_done got %h want 0", dv); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] zv, dv, rv, ev, ez, ed, er;
        ez = runs('{12, 4, 4, 4, 4, 4, 4, 13, 12, 12, 0, 0});
        ed = (128'd1 << 47) | (128'd1 << 72);
        er = (128'd1 << 48) | (128'd1 << 73);
        @(negedge clk);
        in_valid = 1'b1; in_char = 5'd1;
        capture(1'b0, 74, 1, zv, dv, rv, ev);
        checks += 3;
        if (zv !== ez) begin errors++; $display("FAIL b2b_z got %h want %h", zv, ez); end
        if (dv !== ed) begin errors++; $display("FAIL b2b_done got %h want %h", dv, ed); end
        if (rv !== er) begin errors++; $display("FAIL b2b_ready got %h want %h", rv, er); end
    endtask

    task automatic test_reset_mid;
        logic [127:0] zv, dv, rv, ev, ez;
        ez = runs('{4, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        in_valid = 1'b1; in_char = 5'd1;
        capture(1'b0, 17, 0, zv, dv, rv, ev);
        checks += 1;
        if (z !== 1'b1) begin errors++; $display("FAIL rmid_premark got %b want 1", z); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (z !== 1'b0) begin errors++; $display("FAIL rmid_z got %b want 0", z); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 1;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", in_ready); end
        in_valid = 1'b1; in_char = 5'd4;
        capture(1'b0, 17, 0, zv, dv, rv, ev);
        checks += 3;
        if (zv !== ez) begin errors++; $display("FAIL rmid_e_z got %h want %h", zv, ez); end
        if (dv !== 128'd1 << 15) begin errors++; $display("FAIL rmid_e_done got %h want %h", dv, 128'd1 << 15); end
        if (rv !== 128'd1 << 16) begin errors++; $display("FAIL rmid_e_ready got %h want %h", rv, 128'd1 << 16); end
    endtask

    task automatic test_ignore_valid;
        logic [127:0] zv, dv, rv, ev, ez;
        ez = runs('{12, 4, 12, 4, 12, 13, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        in_valid = 1'b1; in_char = 5'd14;
        capture(1'b0, 57, 2, zv, dv, rv, ev);
        checks += 4;
        if (zv !== ez) begin errors++; $display("FAIL ign_z got %h want %h", zv, ez); end
        if (dv !== 128'd1 << 55) begin errors++; $display("FAIL ign_done got %h want %h", dv, 128'd1 << 55); end
        if (rv !== 128'd1 << 56) begin errors++; $display("FAIL ign_ready got %h want %h", rv, 128'd1 << 56); end
        if (ev !== '0) begin errors++; $display("FAIL ign_err got %h want 0", ev); end
    endtask

    initial begin
        test_reset;
        test_letter_a;
        test_unit1_e;
        test_invalid;
        test_back_to_back;
        test_reset_mid;
        test_ignore_valid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/morse_char_encoder.md
MORSE_CHAR_ENCODER -- requirements
Module: morse_char_encoder

Interface
REQ-001 Parameter UNIT_CYCLES, 4, clock cycles per Morse time unit (>=1).
REQ-002 Parameter DASH_UNITS, 3, units per dash mark (>=2).
REQ-003 Parameter LETTER_GAP_UNITS, 3, units of low output after the last symbol of a letter (>=1).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port in_valid  input  1  character offered.
REQ-007 Port in_char  input  5  character code, 0=A through 25=Z.
REQ-008 Port in_ready  output  1  encoder can accept a character.
REQ-009 Port z  output  1  keyed Morse output, 1=mark, 0=space.
REQ-010 Port busy  output  1  a character is being sent.
REQ-011 Port done  output  1  one-cycle pulse: character complete.
REQ-012 Port err  output  1  one-cycle pulse: invalid code accepted and dropped.

Function
REQ-013 States SHALL be IDLE, MARK, SPACE, LGAP.
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 in MARK, SPACE and LGAP.
REQ-015 Transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_valid outside IDLE is ignored.
REQ-016 On transfer of code 0..25: latch length (1..4) and pattern (LSB = first symbol, 1=dash) from the lookup; go to MARK with symbol index 0.
REQ-017 On transfer of code 26..31: stay in IDLE, pulse err in the following cycle, z stays 0.
REQ-018 z SHALL be 1 exactly in MARK and 0 in every other state (registered output).
REQ-019 MARK SHALL last UNIT_CYCLES cycles for a dot, DASH_UNITS*UNIT_CYCLES for a dash.
REQ-020 MARK end: if more symbols remain, go to SPACE for UNIT_CYCLES cycles, then MARK with index+1; otherwise go to LGAP.
REQ-021 LGAP SHALL last LETTER_GAP_UNITS*UNIT_CYCLES cycles; done SHALL pulse in its last cycle; next state IDLE.
REQ-022 First z=1 cycle SHALL be the cycle immediately after transfer; in_ready SHALL return to 1 the cycle after done.
REQ-023 Cycle counter width SHALL be clog2(DASH_UNITS*UNIT_CYCLES, LETTER_GAP_UNITS*UNIT_CYCLES max)+1; counter counts down to 0 with no wrap-around.
REQ-024 A new character SHALL be accepted in the first IDLE cycle (back-to-back with in_valid held gives no extra idle cycles).
REQ-025 Lookup SHALL implement standard International Morse for A-Z.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, z=0, busy=0, done=0, err=0, counter and symbol index 0, regardless of state.
REQ-027 After rst falls, in_ready SHALL be 1 and the first transfer may occur on the next rising edge.
REQ-028 A character interrupted by reset SHALL be abandoned; no done pulse.

Structure
REQ-029 Shared package morse_pkg SHALL hold the state enumeration, character-code width (5), maximum symbol count (4) and the A-Z length/pattern constants.
REQ-030 Combinational sub-module morse_char_rom SHALL map in_char to {valid, length[2:0], pattern[3:0]}.

Verification
REQ-031 Defaults, send A (0): z = 4 high, 4 low, 12 high, then 12 low with done in cycle 32 after transfer; in_ready=1 at cycle 33.
REQ-032 UNIT_CYCLES=1, send E (4): z=1 for 1 cycle, then 3 low cycles, done in the 3rd low cycle.
REQ-033 Send code 27: err pulses once, z stays 0, in_ready stays 1, no done.
REQ-034 in_valid held with B (1) then T (19): B = 12 high, then three of (4 low, 4 high), 12 low; T's 12-cycle mark starts the cycle after in_ready returns.
REQ-035 Assert rst during second mark of B: z=0 and busy=0 without waiting for clk; after release in_ready=1, no done.
REQ-036 Toggle in_valid with varying in_char during MARK of O (14): output unchanged (12H,4L,12H,4L,12H,12L).
